// File: rtl/rsp_s2_dma_pkg.sv
// Shared types and sizing constants for the RSP Stage2 DMA transfer mux.
package rsp_s2_dma_pkg;

  localparam int BURST_CNT_W = 16;
  localparam int MAX_CH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2
  } dma_xfer_state_t;

endpackage

// File: rtl/rsp_s2_dma_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rsp_s2_dma_rr_arb #(
  parameter int NUM_CH = 4,
  localparam int CH_BITS = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]  req,
  input  logic [CH_BITS-1:0] ptr,
  output logic [NUM_CH-1:0]  gnt,
  output logic [CH_BITS-1:0] gnt_idx,
  output logic               gnt_vld
);

  int k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    k       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Walk channels starting at ptr, wrapping modulo NUM_CH.
      k = int'(ptr) + i;
      if (k >= NUM_CH) k = k - NUM_CH;
      if (!gnt_vld && req[k]) begin
        gnt_vld = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = CH_BITS'(k);
      end
    end
  end

endmodule

// File: rtl/rsp_s2_dma_xfer_mux.sv
// N-channel burst mover: round-robin per burst from read FIFOs into one
// shared write FIFO, with stall-timeout detection and per-channel burst counts.
module rsp_s2_dma_xfer_mux
  import rsp_s2_dma_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_WIDTH   = 512,
  parameter int BLEN_BITS    = 8,
  parameter int TIMEOUT_BITS = 16,
  localparam int CH_BITS     = $clog2(NUM_CH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic                              i_enable,
  input  logic [NUM_CH-1:0]                 cfg_ch_en,
  input  logic [TIMEOUT_BITS-1:0]           cfg_timeout_cnt,
  input  logic [NUM_CH-1:0]                 blen_fifo_empty,
  input  logic [NUM_CH*BLEN_BITS-1:0]       blen_fifo_dout,
  output logic [NUM_CH-1:0]                 blen_fifo_pop,
  input  logic [NUM_CH-1:0]                 rfifo_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0]      rfifo_dout,
  output logic [NUM_CH-1:0]                 rfifo_pop,
  input  logic                              wfifo_afull,
  output logic                              wfifo_push,
  output logic [DATA_WIDTH-1:0]             wfifo_din,
  output logic [CH_BITS-1:0]                wfifo_tag,
  output logic                              wfifo_last,
  output logic                              o_busy,
  output logic [NUM_CH*BURST_CNT_W-1:0]     o_ch_bursts,
  output logic                              e_stall_timeout,
  output logic [CH_BITS-1:0]                e_stall_ch
);

  dma_xfer_state_t state, state_n;

  logic [CH_BITS-1:0]                  rr_ptr;
  logic [CH_BITS-1:0]                  gnt_ch;
  logic [CH_BITS-1:0]                  ptr_next;
  logic [NUM_CH-1:0]                   arb_req;
  logic [NUM_CH-1:0]                   arb_gnt;
  logic [CH_BITS-1:0]                  arb_idx;
  logic                                arb_vld;
  logic [BLEN_BITS-1:0]                arb_blen;
  logic [BLEN_BITS-1:0]                beat_cnt;
  logic [TIMEOUT_BITS-1:0]             stall_cnt;
  logic [NUM_CH-1:0][BURST_CNT_W-1:0]  burst_cnt;
  logic                                stall_hit;

  assign arb_req     = cfg_ch_en & ~blen_fifo_empty;
  assign arb_blen    = blen_fifo_dout[arb_idx*BLEN_BITS +: BLEN_BITS];
  assign ptr_next    = (gnt_ch == CH_BITS'(NUM_CH - 1)) ? '0 : gnt_ch + CH_BITS'(1);
  assign o_busy      = (state != ST_IDLE);
  assign o_ch_bursts = burst_cnt;

  rsp_s2_dma_rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req     (arb_req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Datapath is combinational from the FIFO flags; rst blanks it in the same
  // cycle so an abandoned burst issues no further pops.
  always_comb begin
    state_n       = state;
    blen_fifo_pop = '0;
    rfifo_pop     = '0;
    wfifo_push    = 1'b0;
    wfifo_din     = '0;
    wfifo_tag     = '0;
    wfifo_last    = 1'b0;
    stall_hit     = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (i_start) state_n = ST_ARB;
        end
        ST_ARB: begin
          if (!i_enable) begin
            state_n = ST_IDLE;
          end else if (arb_vld) begin
            blen_fifo_pop = arb_gnt;
            state_n       = ST_XFER;
          end
        end
        ST_XFER: begin
          wfifo_din         = rfifo_dout[gnt_ch*DATA_WIDTH +: DATA_WIDTH];
          wfifo_tag         = gnt_ch;
          wfifo_push        = ~rfifo_empty[gnt_ch] & ~wfifo_afull;
          rfifo_pop[gnt_ch] = wfifo_push;
          wfifo_last        = wfifo_push && (beat_cnt == '0);
          stall_hit         = !wfifo_push && (cfg_timeout_cnt != '0) &&
                              (stall_cnt + TIMEOUT_BITS'(1) == cfg_timeout_cnt);
          if (wfifo_last) state_n = i_enable ? ST_ARB : ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      gnt_ch          <= '0;
      beat_cnt        <= '0;
      stall_cnt       <= '0;
      burst_cnt       <= '0;
      e_stall_timeout <= 1'b0;
      e_stall_ch      <= '0;
    end else begin
      state <= state_n;
      if (state == ST_ARB && state_n == ST_XFER) begin
        gnt_ch   <= arb_idx;
        beat_cnt <= arb_blen;
      end else if (wfifo_push) begin
        beat_cnt <= beat_cnt - BLEN_BITS'(1);
      end
      // Saturates so a long stall never wraps back into a second pulse.
      if (state != ST_XFER || wfifo_push) begin
        stall_cnt <= '0;
      end else if (stall_cnt != '1) begin
        stall_cnt <= stall_cnt + TIMEOUT_BITS'(1);
      end
      e_stall_timeout <= stall_hit;
      if (stall_hit) e_stall_ch <= gnt_ch;
      if (i_start) begin
        burst_cnt <= '0;
        rr_ptr    <= '0;
      end else if (wfifo_last) begin
        burst_cnt[gnt_ch] <= burst_cnt[gnt_ch] + BURST_CNT_W'(1);
        rr_ptr            <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_rsp_s2_dma_xfer_mux.sv
// Directed-random bench: FIFO models feed the mux; a burst-level round-robin
// model predicts every pushed beat, tag, last flag and burst count.
module tb_rsp_s2_dma_xfer_mux;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int BL  = 8;
  localparam int TOW = 16;
  localparam int CHB = 2;

  logic                clk;
  logic                rst;
  logic                i_start;
  logic                i_enable;
  logic [NCH-1:0]      cfg_ch_en;
  logic [TOW-1:0]      cfg_timeout_cnt;
  logic [NCH-1:0]      blen_fifo_empty;
  logic [NCH*BL-1:0]   blen_fifo_dout;
  logic [NCH-1:0]      blen_fifo_pop;
  logic [NCH-1:0]      rfifo_empty;
  logic [NCH*DW-1:0]   rfifo_dout;
  logic [NCH-1:0]      rfifo_pop;
  logic                wfifo_afull;
  logic                wfifo_push;
  logic [DW-1:0]       wfifo_din;
  logic [CHB-1:0]      wfifo_tag;
  logic                wfifo_last;
  logic                o_busy;
  logic [NCH*16-1:0]   o_ch_bursts;
  logic                e_stall_timeout;
  logic [CHB-1:0]      e_stall_ch;

  rsp_s2_dma_xfer_mux #(
    .NUM_CH       (NCH),
    .DATA_WIDTH   (DW),
    .BLEN_BITS    (BL),
    .TIMEOUT_BITS (TOW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_enable        (i_enable),
    .cfg_ch_en       (cfg_ch_en),
    .cfg_timeout_cnt (cfg_timeout_cnt),
    .blen_fifo_empty (blen_fifo_empty),
    .blen_fifo_dout  (blen_fifo_dout),
    .blen_fifo_pop   (blen_fifo_pop),
    .rfifo_empty     (rfifo_empty),
    .rfifo_dout      (rfifo_dout),
    .rfifo_pop       (rfifo_pop),
    .wfifo_afull     (wfifo_afull),
    .wfifo_push      (wfifo_push),
    .wfifo_din       (wfifo_din),
    .wfifo_tag       (wfifo_tag),
    .wfifo_last      (wfifo_last),
    .o_busy          (o_busy),
    .o_ch_bursts     (o_ch_bursts),
    .e_stall_timeout (e_stall_timeout),
    .e_stall_ch      (e_stall_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CHB-1:0] tag;
    logic [DW-1:0]  data;
    logic           last;
  } beat_t;

  beat_t         exp_q[$];
  logic [BL-1:0] desc_q[NCH][$];
  logic [DW-1:0] data_q[NCH][$];
  logic [BL-1:0] pend_desc[NCH][$];
  logic [DW-1:0] pend_data[NCH][$];
  logic [NCH-1:0] stuck;
  int exp_bursts[NCH];
  int model_ptr;

  int n_assert, n_fail;
  int cyc, pushes_t, lasts_t, blen_pops_t, pulses, pulse_cyc, last_push_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_inputs();
    for (int c = 0; c < NCH; c++) begin
      blen_fifo_empty[c]       = (desc_q[c].size() == 0);
      blen_fifo_dout[c*BL +: BL] = (desc_q[c].size() != 0) ? desc_q[c][0] : '0;
      rfifo_empty[c]           = (data_q[c].size() == 0) || stuck[c];
      rfifo_dout[c*DW +: DW]   = (data_q[c].size() != 0) ? data_q[c][0] : '0;
    end
  endtask

  task automatic add_burst(input int ch, input int blen, input bit modelled);
    logic [DW-1:0] d;
    desc_q[ch].push_back(BL'(blen));
    if (modelled) pend_desc[ch].push_back(BL'(blen));
    for (int j = 0; j <= blen; j++) begin
      d = $urandom;
      data_q[ch].push_back(d);
      if (modelled) pend_data[ch].push_back(d);
    end
  endtask

  // Burst-level round robin over the queued descriptors of enabled channels.
  task automatic model_resolve();
    int found, k;
    logic [BL-1:0] b;
    beat_t e;
    for (int it = 0; it < 64; it++) begin
      found = -1;
      for (int i = 0; i < NCH; i++) begin
        k = (model_ptr + i) % NCH;
        if (found < 0 && cfg_ch_en[k] && pend_desc[k].size() > 0) found = k;
      end
      if (found < 0) break;
      b = pend_desc[found].pop_front();
      for (int j = 0; j <= int'(b); j++) begin
        e.tag  = CHB'(found);
        e.data = pend_data[found].pop_front();
        e.last = (j == int'(b));
        exp_q.push_back(e);
      end
      model_ptr = (found + 1) % NCH;
    end
  endtask

  task automatic step();
    logic [NCH-1:0] bp, rp, ep;
    beat_t e;
    @(negedge clk);
    cyc++;
    ep = '0;
    if (wfifo_push) ep[wfifo_tag] = 1'b1;
    chk("rfifo_pop_vs_push", rfifo_pop, ep);
    chk("push_under_afull", wfifo_push & wfifo_afull, 0);
    chk("last_without_push", wfifo_last & ~wfifo_push, 0);
    chk("desc_pop_disabled", blen_fifo_pop & ~cfg_ch_en, 0);
    if (wfifo_push) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_push", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_tag", wfifo_tag, e.tag);
        chk("beat_din", wfifo_din, e.data);
        chk("beat_last", wfifo_last, e.last);
        if (e.last) exp_bursts[e.tag]++;
      end
      pushes_t++;
      last_push_cyc = cyc;
    end
    if (wfifo_last) lasts_t++;
    if (e_stall_timeout === 1'b1) begin
      pulses++;
      pulse_cyc = cyc;
    end
    bp = blen_fifo_pop;
    rp = rfifo_pop;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (bp[c]) begin
        blen_pops_t++;
        if (desc_q[c].size() != 0) void'(desc_q[c].pop_front());
      end
      if (rp[c] && data_q[c].size() != 0) void'(data_q[c].pop_front());
    end
    update_inputs();
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    model_ptr = 0;
    for (int c = 0; c < NCH; c++) exp_bursts[c] = 0;
    step();
    i_start = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic chk_bursts(input string tag);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("%s_ch%0d", tag, c), o_ch_bursts[c*16 +: 16], exp_bursts[c]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_push"}, wfifo_push, 0);
    chk({tag, "_din"}, wfifo_din, 0);
    chk({tag, "_tag"}, wfifo_tag, 0);
    chk({tag, "_last"}, wfifo_last, 0);
    chk({tag, "_blen_pop"}, blen_fifo_pop, 0);
    chk({tag, "_rfifo_pop"}, rfifo_pop, 0);
    chk({tag, "_bursts"}, o_ch_bursts, 0);
    chk({tag, "_e_to"}, e_stall_timeout, 0);
    chk({tag, "_e_ch"}, e_stall_ch, 0);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0; model_ptr = 0;
    pushes_t = 0; lasts_t = 0; blen_pops_t = 0; pulses = 0; pulse_cyc = 0; last_push_cyc = 0;
    for (int c = 0; c < NCH; c++) exp_bursts[c] = 0;
    rst = 1'b1; i_start = 1'b0; i_enable = 1'b1; cfg_ch_en = '1;
    cfg_timeout_cnt = '0; wfifo_afull = 1'b0; stuck = '0;
    blen_fifo_dout = '0; rfifo_dout = '0;
    update_inputs();

    // Reset state
    step(); step();
    check_zero("reset");
    rst = 1'b0;
    step();

    // Round-robin fairness: two 4-beat bursts per channel
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++) add_burst(c, 3, 1);
    update_inputs();
    pushes_t = 0; lasts_t = 0;
    pulse_start();
    model_resolve();
    drain("rr_drain", 200);
    step();
    chk("rr_pushes", pushes_t, 32);
    chk("rr_lasts", lasts_t, 8);
    chk_bursts("rr_bursts");

    // Backpressure: afull for 5 cycles mid-burst
    add_burst(0, 7, 1);
    update_inputs();
    model_resolve();
    pushes_t = 0; lasts_t = 0;
    for (int i = 0; i < 20 && pushes_t < 3; i++) step();
    wfifo_afull = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("bp_pushes_held", pushes_t, 3);
    wfifo_afull = 1'b0;
    drain("bp_drain", 40);
    chk("bp_pushes", pushes_t, 8);
    chk("bp_lasts", lasts_t, 1);

    // Stall timeout on ch2
    cfg_timeout_cnt = 16'd10;
    add_burst(2, 5, 1);
    update_inputs();
    model_resolve();
    pushes_t = 0; pulses = 0;
    for (int i = 0; i < 20 && pushes_t < 2; i++) step();
    stuck[2] = 1'b1;
    update_inputs();
    for (int i = 0; i < 30; i++) step();
    chk("to_pulses", pulses, 1);
    chk("to_delay", pulse_cyc - last_push_cyc, 11);
    chk("to_ch", e_stall_ch, 2);
    stuck[2] = 1'b0;
    update_inputs();
    drain("to_drain", 40);
    step();
    chk("to_no_repulse", pulses, 1);
    chk("to_ch_held", e_stall_ch, 2);
    cfg_timeout_cnt = '0;

    // Drop enable during an 8-beat burst
    add_burst(0, 7, 1);
    update_inputs();
    model_resolve();
    pushes_t = 0; lasts_t = 0;
    for (int i = 0; i < 20 && pushes_t < 1; i++) step();
    i_enable = 1'b0;
    add_burst(1, 3, 0);
    update_inputs();
    blen_pops_t = 0;
    for (int i = 0; i < 20; i++) step();
    chk("dis_pushes", pushes_t, 8);
    chk("dis_lasts", lasts_t, 1);
    chk("dis_busy", o_busy, 0);
    chk("dis_desc_pops", blen_pops_t, 0);
    chk("dis_desc_left", desc_q[1].size(), 1);
    desc_q[1].delete(); data_q[1].delete();
    update_inputs();

    // Max burst on ch1 only, other channels loaded but disabled
    cfg_ch_en = 4'b0010;
    add_burst(1, 255, 1);
    add_burst(0, 0, 0); add_burst(2, 0, 0); add_burst(3, 0, 0);
    update_inputs();
    i_enable = 1'b1;
    pushes_t = 0;
    pulse_start();
    model_resolve();
    drain("max_drain", 400);
    step();
    chk("max_pushes", pushes_t, 256);
    chk("max_ch0_desc", desc_q[0].size(), 1);
    chk("max_ch2_data", data_q[2].size(), 1);
    chk("max_ch3_desc", desc_q[3].size(), 1);
    chk_bursts("max_bursts");
    for (int c = 0; c < NCH; c++) begin
      if (c != 1) begin desc_q[c].delete(); data_q[c].delete(); end
    end
    cfg_ch_en = '1;
    update_inputs();

    // Reset at beat 3, then restart from ch0
    add_burst(2, 7, 1);
    update_inputs();
    model_resolve();
    pushes_t = 0;
    for (int i = 0; i < 20 && pushes_t < 3; i++) step();
    rst = 1'b1;
    exp_q.delete();
    desc_q[2].delete(); data_q[2].delete();
    for (int c = 0; c < NCH; c++) exp_bursts[c] = 0;
    update_inputs();
    step();
    rst = 1'b0;
    check_zero("rst_mid");
    add_burst(3, 1, 1);
    add_burst(0, 1, 1);
    update_inputs();
    pulse_start();
    model_resolve();
    drain("rst_restart_drain", 40);
    step();
    chk_bursts("rst_restart_bursts");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
